// File: rtl/bus_cycle_initiator.sv
// Host-request to T1..T4 bus cycle initiator with READY wait states.
// Define BUS_TIMEOUT_EN to build the READY-low abort counter (TIMEOUT_CYCLES).
module bus_cycle_initiator #(
    parameter int unsigned ADDR_WIDTH     = 20,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] Address,
    inout  wire  [DATA_WIDTH-1:0] Data,
    output logic                  CS,
    output logic                  OE,
    output logic                  WR,
    input  logic                  READY
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        TW   = 3'd4,
        T4   = 3'd5
    } state_t;

    state_t                  state, next_state;
    logic                    write_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    handshake;
    logic                    strobe;
    logic                    in_wait;
    logic                    tmo_hit;

    assign req_ready = (state == IDLE) || (state == T4);
    assign handshake = req_valid && req_ready;
    assign strobe    = (state == T2) || (state == T3) || (state == TW);
    assign in_wait   = (state == T3) || (state == TW);

    assign CS        = (state == T1) || strobe;
    assign OE        = !(strobe && !write_q);
    assign WR        = !(strobe && write_q);
    assign Data      = (strobe && write_q) ? wdata_q : 'z;
    assign Address   = addr_q;
    assign rsp_valid = (state == T4);
    assign rsp_rdata = rdata_q;

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (handshake) next_state = T1;
            T1:      next_state = T2;
            T2:      next_state = T3;
            T3, TW:  next_state = (READY || tmo_hit) ? T4 : TW;
            T4:      next_state = handshake ? T1 : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= next_state;
            if (handshake) begin
                write_q <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            // Only reads refresh rsp_rdata; a write completion leaves the last read value visible.
            if (in_wait && READY && !write_q)
                rdata_q <= Data;
            else if (tmo_hit)
                rdata_q <= '1;
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    // Abort on the TIMEOUT_CYCLES-th consecutive READY-low cycle in T3/TW.
    assign tmo_hit = in_wait && !READY && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign rsp_err = err_q && (state == T4);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == T1)
                wait_cnt <= '0;
            else if (in_wait && !READY)
                wait_cnt <= wait_cnt + 1'b1;
            if (in_wait && READY)
                err_q <= 1'b0;
            else if (tmo_hit)
                err_q <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_cycle_initiator.sv
// Self-checking bench: vector table, back-to-back/reset/stall sequences, random transactions vs. memory model.
`timescale 1ns/1ps
module tb_bus_cycle_initiator;
    localparam int unsigned AW  = 20;
    localparam int unsigned DW  = 8;
    localparam int unsigned TMO = 16;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          req_valid, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          req_ready, rsp_valid, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] Address;
    wire  [DW-1:0] Data;
    logic          CS, OE, WR, READY;

    always #5 CLK = ~CLK;

    bus_cycle_initiator #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .Address(Address), .Data(Data), .CS(CS), .OE(OE), .WR(WR), .READY(READY)
    );

    // Responder: 1024-byte memory decoded on Address[9:0]; READY low for wait_cfg cycles from T3.
    logic [DW-1:0] resp_mem [1024];
    logic          mem_init;
    int unsigned   st_cnt;
    int unsigned   wait_cfg;

    assign Data = (CS && !OE) ? resp_mem[Address[9:0]] : 'z;
    always_comb READY = (st_cnt == 0) || (st_cnt > wait_cfg);

    always @(posedge CLK) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) resp_mem[i] <= DW'(i) ^ 8'h3C;
            resp_mem[10'h020] <= 8'h5C;
        end else if (CS && !WR) begin
            resp_mem[Address[9:0]] <= Data;
        end
        if (RESET) st_cnt <= 0;
        else       st_cnt <= (CS && (!OE || !WR)) ? st_cnt + 1 : 0;
    end

    logic [DW-1:0] model_mem [1024];
    logic [DW-1:0] last_rd;
    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Called just after a negedge with the block idle; returns just after a negedge, one cycle past T4.
    task automatic run_txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int unsigned w, input logic glitch,
                           output int unsigned cyc, output logic [DW-1:0] rd, output logic er,
                           output logic ok, output string why);
        int unsigned exp_t4, guard;
        logic        strb;
        exp_t4 = 4 + w;
`ifdef BUS_TIMEOUT_EN
        if (w >= TMO) exp_t4 = 3 + TMO;
`endif
        cyc = 0; rd = '0; er = 1'b0; ok = 1'b1; why = "";
        wait_cfg  = w;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        guard = 0;
        while (!req_ready && guard < 50) begin @(negedge CLK); guard++; end
        @(negedge CLK);
        req_valid = 1'b0; req_write = ~wr; req_addr = ~a; req_wdata = ~d;
        for (int unsigned k = 1; k <= exp_t4 + 8; k++) begin
            if (glitch && k == 2) req_valid = 1'b1;
            if (k == 3) req_valid = 1'b0;
            strb = (k >= 2) && (k < exp_t4);
            if (ok && k <= exp_t4 &&
                (Address !== a || CS !== (k < exp_t4) || OE !== !(strb && !wr) ||
                 WR !== !(strb && wr) || req_ready !== (k == exp_t4) ||
                 rsp_valid !== (k == exp_t4) || (strb && wr && Data !== d))) begin
                ok  = 1'b0;
                why = $sformatf("@k%0d_CS%b_OE%b_WR%b_rv%b", k, CS, OE, WR, rsp_valid);
            end
            if (rsp_valid) begin cyc = k; rd = rsp_rdata; er = rsp_err; break; end
            @(negedge CLK);
        end
        @(negedge CLK);
        if (ok && (CS !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1)) begin
            ok = 1'b0; why = "@post_idle";
        end
    endtask

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int unsigned   waits;
        logic [DW-1:0] exp_rdata;
        int unsigned   exp_cyc;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned   cyc, pulses;
        logic [DW-1:0] rd;
        logic          er, ok;
        string         why;

        vecs[0] = '{1'b1, 20'h00010, 8'hA5, 0, 8'h00, 4};
        vecs[1] = '{1'b0, 20'h00020, 8'h00, 0, 8'h5C, 4};
        vecs[2] = '{1'b0, 20'h00020, 8'h00, 3, 8'h5C, 7};
        vecs[3] = '{1'b0, 20'h00010, 8'h00, 1, 8'hA5, 5};
        vecs[4] = '{1'b1, 20'h003FF, 8'h00, 2, 8'hA5, 6};
        vecs[5] = '{1'b0, 20'h003FF, 8'h00, 0, 8'h00, 4};
        vecs[6] = '{1'b1, 20'hFFC00, 8'hFF, 0, 8'h00, 4};
        vecs[7] = '{1'b0, 20'h00000, 8'h00, 5, 8'hFF, 9};  // responder decodes only Address[9:0]

        for (int i = 0; i < 1024; i++) model_mem[i] = DW'(i) ^ 8'h3C;
        model_mem[10'h020] = 8'h5C;
        last_rd = '0;

        RESET = 1'b1; mem_init = 1'b1; wait_cfg = 0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge CLK);
        chk("rst_address",   Address, 0);
        chk("rst_cs_oe_wr",  {CS, OE, WR}, 3'b011);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err",   rsp_err, 0);
        RESET = 1'b0; mem_init = 1'b0;
        @(negedge CLK);

        foreach (vecs[i]) begin
            run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].waits, 1'b0, cyc, rd, er, ok, why);
            chk($sformatf("vec%0d_cycles", i), cyc, vecs[i].exp_cyc);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), er, 0);
            chk($sformatf("vec%0d_wave%s", i, why), ok, 1);
            if (vecs[i].wr) begin
                model_mem[vecs[i].addr[9:0]] = vecs[i].wdata;
                chk($sformatf("vec%0d_mem", i), resp_mem[vecs[i].addr[9:0]], vecs[i].wdata);
            end else begin
                last_rd = vecs[i].exp_rdata;
            end
        end

        // Back-to-back: request held through the write so the read handshakes in T4.
        wait_cfg = 0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 20'h00055; req_wdata = 8'h11;
        @(negedge CLK);
        req_write = 1'b0; req_wdata = 8'hEE;
        @(negedge CLK);
        chk("b2b_wr_strobe", {OE, WR, Data}, {1'b1, 1'b0, 8'h11});
        repeat (2) @(negedge CLK);
        chk("b2b_wr_done", {rsp_valid, req_ready}, 2'b11);
        @(negedge CLK);
        chk("b2b_rd_t1", {CS, OE, WR, rsp_valid}, 4'b1110);
        req_valid = 1'b0;
        @(negedge CLK);
        chk("b2b_rd_strobe", {OE, WR}, 2'b01);
        repeat (2) @(negedge CLK);
        chk("b2b_rd_done", {rsp_valid, rsp_err}, 2'b10);
        chk("b2b_rd_data", rsp_rdata, 8'h11);
        model_mem[10'h055] = 8'h11;
        last_rd = 8'h11;
        @(negedge CLK);

        for (int i = 0; i < 40; i++) begin
            logic          wr, gl;
            logic [AW-1:0] a;
            logic [DW-1:0] d, exp_rd;
            int unsigned   w;
            wr = 1'($urandom_range(0, 1));
            a  = {10'($urandom), 6'd0, 4'($urandom)};
            d  = 8'($urandom);
            w  = $urandom_range(0, 5);
            gl = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 2)) @(negedge CLK);
            if (wr) begin
                model_mem[a[9:0]] = d;
                exp_rd = last_rd;
            end else begin
                exp_rd  = model_mem[a[9:0]];
                last_rd = exp_rd;
            end
            run_txn(wr, a, d, w, gl, cyc, rd, er, ok, why);
            chk($sformatf("rnd%0d_cycles", i), cyc, 4 + w);
            chk($sformatf("rnd%0d_rdata", i), rd, exp_rd);
            chk($sformatf("rnd%0d_err", i), er, 0);
            chk($sformatf("rnd%0d_wave%s", i, why), ok, 1);
            chk($sformatf("rnd%0d_mem", i), resp_mem[a[9:0]], model_mem[a[9:0]]);
        end

`ifdef BUS_TIMEOUT_EN
        run_txn(1'b0, 20'h00030, 8'h00, 100, 1'b0, cyc, rd, er, ok, why);
        chk("tmo_cycles", cyc, 3 + TMO);
        chk("tmo_rdata", rd, 8'hFF);
        chk("tmo_err", er, 1);
        chk({"tmo_wave", why}, ok, 1);
`else
        wait_cfg = 1000;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 20'h00030;
        @(negedge CLK);
        req_valid = 1'b0;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            if (rsp_valid) pulses++;
            @(negedge CLK);
        end
        chk("stall_no_completion", pulses, 0);
        chk("stall_still_waiting", {CS, OE, WR}, 3'b101);
`endif
        RESET = 1'b1;
        @(negedge CLK);
        chk("stall_rst_bus", {CS, OE, WR, rsp_valid, req_ready}, 5'b01101);
        chk("stall_rst_rdata", rsp_rdata, 0);
        RESET = 1'b0; wait_cfg = 0; last_rd = '0;
        @(negedge CLK);

        // Reset lands while a write sits in T3.
        wait_cfg = 1000;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 20'h00077; req_wdata = 8'h3E;
        @(negedge CLK);
        req_valid = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_t3_pre", {CS, OE, WR}, 3'b110);
        RESET = 1'b1;
        @(negedge CLK);
        chk("rst_t3_cs_oe_wr", {CS, OE, WR}, 3'b011);
        chk("rst_t3_rsp_valid", rsp_valid, 0);
        chk("rst_t3_req_ready", req_ready, 1);
        chk("rst_t3_address", Address, 0);
        RESET = 1'b0; wait_cfg = 0;
        model_mem[10'h077] = 8'h3E;
        pulses = 0;
        repeat (5) begin
            @(negedge CLK);
            if (rsp_valid || CS) pulses++;
        end
        chk("rst_t3_quiet", pulses, 0);

        run_txn(1'b0, 20'h00077, 8'h00, 0, 1'b0, cyc, rd, er, ok, why);
        chk("post_rst_cycles", cyc, 4);
        chk("post_rst_rdata", rd, model_mem[10'h077]);
        chk({"post_rst_wave", why}, ok, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
